// File: rtl/apb_xfer_sequencer.sv
// APB-side transfer sequencer: splits one AHB-sized request into APB_DW-wide
// APB SETUP/ACCESS beats, with wait states, slave error and wait-state timeout.
module apb_xfer_sequencer #(
    parameter int AHB_AW  = 32,
    parameter int AHB_DW  = 32,
    parameter int APB_DW  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic              i_start_read,
    input  logic              i_start_write,
    input  logic [AHB_AW-1:0] i_addr,
    input  logic [2:0]        i_size,
    input  logic [AHB_DW-1:0] i_wdata,
    input  logic              i_fifo_empty,
    output logic              o_fifo_pop,
    output logic [AHB_AW-1:0] o_PADDR,
    output logic              o_PSEL,
    output logic              o_PENABLE,
    output logic              o_PWRITE,
    output logic [APB_DW-1:0] o_PWDATA,
    input  logic [APB_DW-1:0] i_PRDATA,
    input  logic              i_PREADY,
    input  logic              i_PSLVERR,
    output logic [AHB_DW-1:0] o_rdata,
    output logic              o_done,
    output logic              o_err,
    output logic              o_busy
);

    localparam int AHB_BYTES = AHB_DW / 8;
    localparam int APB_BYTES = APB_DW / 8;
    localparam int LANES     = AHB_DW / APB_DW;
    localparam int MAX_SIZE  = $clog2(AHB_BYTES);
    localparam int APB_SHIFT = $clog2(APB_BYTES);
    localparam int KW        = $clog2(LANES + 1);
    localparam int LW        = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int TW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    // IDLE: arbitrate | SETUP: PSEL only | ACCESS: PENABLE, wait PREADY | DONE: pulse done/err
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    state_t             state, state_n;
    logic [AHB_AW-1:0]  base_q;
    logic [LW-1:0]      lane0_q;
    logic [KW-1:0]      beats_q;
    logic [KW-1:0]      k_q;
    logic               write_q;
    logic               err_q;
    logic [AHB_DW-1:0]  wdata_q;
    logic [AHB_DW-1:0]  rdata_q;
    logic [TW-1:0]      wait_q;

    logic [2:0]         size_c;
    logic [KW-1:0]      beats_c;
    logic [LW-1:0]      lane0_c;
    logic [AHB_AW-1:0]  base_c;
    logic [LW-1:0]      lane_idx;
    logic               take_wr;
    logic               take_rd;
    logic               beat_ok;
    logic               timed_out;
    logic               last_beat;

    always_comb begin
        size_c  = (i_size > 3'(MAX_SIZE)) ? 3'(MAX_SIZE) : i_size;
        beats_c = (size_c > 3'(APB_SHIFT)) ? (KW'(1) << (size_c - 3'(APB_SHIFT))) : KW'(1);
        lane0_c = LW'((i_addr >> APB_SHIFT) & AHB_AW'(LANES - 1));
        // sub-APB-width transfers keep their byte address; wider ones start on an APB word
        base_c  = (beats_c > KW'(1)) ? (i_addr & ~AHB_AW'(APB_BYTES - 1)) : i_addr;
    end

    assign take_wr   = i_start_write && !i_fifo_empty;
    assign take_rd   = !take_wr && i_start_read;
    assign lane_idx  = lane0_q + k_q[LW-1:0];
    assign last_beat = (k_q == beats_q - KW'(1));
    assign beat_ok   = (state == ACCESS) && i_PREADY;
    assign timed_out = (TIMEOUT != 0) && (state == ACCESS) && !i_PREADY
                       && (wait_q == TW'(TIMEOUT - 1));

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n    = state;
        o_PSEL     = 1'b0;
        o_PENABLE  = 1'b0;
        o_done     = 1'b0;
        o_err      = 1'b0;
        o_fifo_pop = 1'b0;
        case (state)
            IDLE: begin
                if (take_wr) begin
                    o_fifo_pop = 1'b1;
                    state_n    = SETUP;
                end else if (take_rd) begin
                    state_n = SETUP;
                end
            end
            SETUP: begin
                o_PSEL  = 1'b1;
                state_n = ACCESS;
            end
            ACCESS: begin
                o_PSEL    = 1'b1;
                o_PENABLE = 1'b1;
                if (beat_ok) begin
                    state_n = (i_PSLVERR || last_beat) ? DONE : SETUP;
                end else if (timed_out) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                o_done  = 1'b1;
                o_err   = err_q;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            base_q  <= '0;
            lane0_q <= '0;
            beats_q <= '0;
            k_q     <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            wait_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (take_wr || take_rd) begin
                        base_q  <= base_c;
                        lane0_q <= lane0_c;
                        beats_q <= beats_c;
                        k_q     <= '0;
                        write_q <= take_wr;
                        err_q   <= 1'b0;
                        if (take_wr) begin
                            wdata_q <= i_wdata;
                        end else begin
                            rdata_q <= '0;
                        end
                    end
                end
                SETUP: begin
                    wait_q <= '0;
                end
                ACCESS: begin
                    if (beat_ok) begin
                        if (!write_q) begin
                            rdata_q[lane_idx*APB_DW +: APB_DW] <= i_PRDATA;
                        end
                        if (i_PSLVERR) begin
                            err_q <= 1'b1;
                        end else if (!last_beat) begin
                            k_q <= k_q + KW'(1);
                        end
                    end else begin
                        wait_q <= wait_q + TW'(1);
                        if (timed_out) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    err_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign o_PADDR  = base_q + (AHB_AW'(k_q) << APB_SHIFT);
    assign o_PWDATA = wdata_q[lane_idx*APB_DW +: APB_DW];
    assign o_PWRITE = write_q;
    assign o_rdata  = rdata_q;
    assign o_busy   = (state != IDLE);

endmodule

// File: tb/tb_apb_xfer_sequencer.sv
// Randomized bench for apb_xfer_sequencer; a transfer-level model derives the
// expected APB beats, cycle-by-cycle strobes, read data and error outcome.
module tb_apb_xfer_sequencer;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int PW    = 8;
    localparam int TO    = 16;
    localparam int PB    = PW / 8;
    localparam int AB    = DW / 8;
    localparam int MAXS  = $clog2(AB);

    logic          HCLK = 1'b0;
    logic          HRESET;
    logic          i_start_read, i_start_write, i_fifo_empty;
    logic [AW-1:0] i_addr;
    logic [2:0]    i_size;
    logic [DW-1:0] i_wdata;
    logic          o_fifo_pop;
    logic [AW-1:0] o_PADDR;
    logic          o_PSEL, o_PENABLE, o_PWRITE;
    logic [PW-1:0] o_PWDATA;
    logic [PW-1:0] i_PRDATA;
    logic          i_PREADY, i_PSLVERR;
    logic [DW-1:0] o_rdata;
    logic          o_done, o_err, o_busy;

    apb_xfer_sequencer #(.AHB_AW(AW), .AHB_DW(DW), .APB_DW(PW), .TIMEOUT(TO)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .i_start_read(i_start_read), .i_start_write(i_start_write),
        .i_addr(i_addr), .i_size(i_size), .i_wdata(i_wdata),
        .i_fifo_empty(i_fifo_empty), .o_fifo_pop(o_fifo_pop),
        .o_PADDR(o_PADDR), .o_PSEL(o_PSEL), .o_PENABLE(o_PENABLE),
        .o_PWRITE(o_PWRITE), .o_PWDATA(o_PWDATA), .i_PRDATA(i_PRDATA),
        .i_PREADY(i_PREADY), .i_PSLVERR(i_PSLVERR), .o_rdata(o_rdata),
        .o_done(o_done), .o_err(o_err), .o_busy(o_busy)
    );

    always #5 HCLK = ~HCLK;

    int            checks   = 0;
    int            failures = 0;
    logic [DW-1:0] hold_rdata;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // scramble request-side inputs while busy; the DUT must ignore them
    task automatic scramble(input bit rd, input bit wr, input bit sticky);
        i_start_read  = rd & sticky;
        i_start_write = wr & sticky;
        i_addr        = $urandom;
        i_wdata       = $urandom;
        i_size        = 3'($urandom);
        i_fifo_empty  = 1'($urandom);
    endtask

    // waits: 8 bits per beat (>= TO means PREADY never rises); errbeat: beat with PSLVERR, -1 none
    task automatic do_xfer(input bit rd, input bit wr, input bit empty,
                           input logic [AW-1:0] addr, input logic [2:0] size,
                           input logic [DW-1:0] wdata, input logic [DW-1:0] pdata,
                           input logic [31:0] waits, input int errbeat, input bit sticky);
        bit            sw, sr, tmo, rdy, exp_err;
        int            sz, beats, lane0, lane, w, nacc;
        logic [AW-1:0] base, pa;
        logic [DW-1:0] exp_rd;
        sw = wr && !empty;
        sr = !sw && rd;
        @(negedge HCLK);
        i_start_read = rd; i_start_write = wr; i_fifo_empty = empty;
        i_addr = addr; i_size = size; i_wdata = wdata;
        i_PREADY = 1'b0; i_PSLVERR = 1'b0;
        #1;
        chk("t0_busy", o_busy, 0);
        chk("t0_pop", o_fifo_pop, sw);
        if (!sw && !sr) begin
            @(negedge HCLK);
            i_start_read = 0; i_start_write = 0;
            #1;
            chk("no_accept_busy", o_busy, 0);
            return;
        end
        sz    = (int'(size) > MAXS) ? MAXS : int'(size);
        beats = (1 << sz) / PB;
        if (beats < 1) beats = 1;
        lane0 = (int'(addr) % AB) / PB;
        base  = (beats > 1) ? (addr & ~32'(PB - 1)) : addr;
        exp_rd  = '0;
        exp_err = 1'b0;
        for (int b = 0; b < beats; b++) begin
            w    = int'(waits[b*8 +: 8]);
            tmo  = (TO != 0) && (w >= TO);
            nacc = tmo ? TO : w + 1;
            lane = lane0 + b;
            pa   = base + AW'(b * PB);
            @(negedge HCLK);
            scramble(rd, wr, sticky);
            i_PREADY = 1'b0; i_PSLVERR = 1'($urandom); i_PRDATA = PW'($urandom);
            #1;
            chk("setup_psel", o_PSEL, 1);
            chk("setup_penable", o_PENABLE, 0);
            chk("setup_paddr", o_PADDR, pa);
            chk("setup_pwrite", o_PWRITE, sw);
            chk("setup_done", o_done, 0);
            if (sw) chk("setup_pwdata", o_PWDATA, wdata[lane*PW +: PW]);
            for (int j = 0; j < nacc; j++) begin
                @(negedge HCLK);
                scramble(rd, wr, sticky);
                rdy       = !tmo && (j == w);
                i_PREADY  = rdy;
                i_PRDATA  = rdy ? pdata[b*PW +: PW] : PW'($urandom);
                i_PSLVERR = rdy ? (b == errbeat) : 1'($urandom);
                #1;
                chk("acc_psel", o_PSEL, 1);
                chk("acc_penable", o_PENABLE, 1);
                chk("acc_paddr", o_PADDR, pa);
                chk("acc_pwrite", o_PWRITE, sw);
                chk("acc_done", o_done, 0);
                chk("acc_pop", o_fifo_pop, 0);
                if (sw) chk("acc_pwdata", o_PWDATA, wdata[lane*PW +: PW]);
            end
            if (tmo) begin
                exp_err = 1'b1;
                break;
            end
            if (sr) exp_rd[lane*PW +: PW] = pdata[b*PW +: PW];
            if (b == errbeat) begin
                exp_err = 1'b1;
                break;
            end
        end
        @(negedge HCLK);
        i_start_read = 0; i_start_write = 0;
        i_PREADY = 1'b0; i_PSLVERR = 1'b0;
        #1;
        chk("done_pulse", o_done, 1);
        chk("done_err", o_err, exp_err);
        chk("done_psel", o_PSEL, 0);
        chk("done_penable", o_PENABLE, 0);
        chk("done_busy", o_busy, 1);
        if (sr) hold_rdata = exp_rd;
        chk("done_rdata", o_rdata, hold_rdata);
        @(negedge HCLK);
        #1;
        chk("idle_busy", o_busy, 0);
        chk("idle_done", o_done, 0);
        chk("idle_err", o_err, 0);
        chk("idle_rdata", o_rdata, hold_rdata);
    endtask

    task automatic reset_mid_access();
        @(negedge HCLK);
        i_start_write = 1; i_start_read = 0; i_fifo_empty = 0;
        i_addr = 32'h300; i_size = 3'd2; i_wdata = 32'hCAFEF00D; i_PREADY = 0;
        @(negedge HCLK);
        i_start_write = 0;
        @(negedge HCLK);
        @(negedge HCLK);
        #1;
        chk("rst_pre_penable", o_PENABLE, 1);
        #2;
        HRESET = 1'b1;
        #1;
        chk("rst_psel", o_PSEL, 0);
        chk("rst_penable", o_PENABLE, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_paddr", o_PADDR, 0);
        chk("rst_pwdata", o_PWDATA, 0);
        chk("rst_pwrite", o_PWRITE, 0);
        chk("rst_rdata", o_rdata, 0);
        @(negedge HCLK);
        HRESET = 1'b0;
        hold_rdata = '0;
        @(negedge HCLK);
        #1;
        chk("rst_after_busy", o_busy, 0);
    endtask

    initial begin
        int          sz_c, ebeat;
        logic [2:0]  sz_r;
        logic [31:0] wt, ad;
        HRESET = 1'b1;
        i_start_read = 0; i_start_write = 0; i_fifo_empty = 1;
        i_addr = '0; i_size = '0; i_wdata = '0;
        i_PRDATA = '0; i_PREADY = 0; i_PSLVERR = 0;
        hold_rdata = '0;
        #1;
        chk("reset_busy", o_busy, 0);
        chk("reset_psel", o_PSEL, 0);
        chk("reset_penable", o_PENABLE, 0);
        chk("reset_pwrite", o_PWRITE, 0);
        chk("reset_paddr", o_PADDR, 0);
        chk("reset_pwdata", o_PWDATA, 0);
        chk("reset_rdata", o_rdata, 0);
        chk("reset_done", {o_done, o_err, o_fifo_pop}, 0);
        @(negedge HCLK);
        @(negedge HCLK);
        HRESET = 1'b0;

        do_xfer(1, 0, 1, 32'h100, 3'd2, 32'h0,        32'h44332211, 32'h0, -1, 0);
        do_xfer(0, 1, 0, 32'h202, 3'd1, 32'hAABBCCDD, 32'h0,        32'h0, -1, 0);
        do_xfer(1, 0, 0, 32'h45,  3'd0, 32'h0,        32'h5A,       32'h3, -1, 0);
        do_xfer(0, 1, 0, 32'h400, 3'd2, 32'h12345678, 32'h0,        32'h0,  1, 0);
        do_xfer(0, 1, 0, 32'h500, 3'd2, 32'h87654321, 32'h0,        32'hFF, -1, 0);
        do_xfer(1, 1, 0, 32'h600, 3'd2, 32'h0BADBEEF, 32'h0,        32'h0, -1, 0);
        do_xfer(1, 0, 0, 32'h600, 3'd2, 32'h0,        32'h0DD0F00D, 32'h0, -1, 0);
        do_xfer(1, 1, 1, 32'h702, 3'd1, 32'h0,        32'h9977,     32'h0, -1, 0);
        do_xfer(0, 1, 1, 32'h800, 3'd2, 32'h0,        32'h0,        32'h0, -1, 0);
        do_xfer(1, 0, 0, 32'h904, 3'd7, 32'h0,        32'hA1B2C3D4, 32'h01000200, -1, 0);
        reset_mid_access();

        for (int n = 0; n < 80; n++) begin
            sz_r = 3'($urandom);
            sz_c = (int'(sz_r) > MAXS) ? MAXS : int'(sz_r);
            ad   = $urandom & ~32'((1 << sz_c) - 1);
            wt   = {6'd0, 2'($urandom), 6'd0, 2'($urandom), 6'd0, 2'($urandom), 6'd0, 2'($urandom)};
            if ($urandom_range(0, 19) == 0) wt[$urandom_range(0, 3)*8 +: 8] = 8'hFF;
            ebeat = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3)) : -1;
            do_xfer(1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0), ad, sz_r,
                    $urandom, $urandom, wt, ebeat, 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
